// File: rtl/lapido_mem_pkg.sv
// Shared definitions for the Lapido MEM stage: access-size encodings,
// FSM state type and the default bus timeout.
package lapido_mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the MEM stage: byte enables, store-data
// replication, load extraction/extension and misalignment detection.
module mem_lane_align
  import lapido_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        signed_load,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Decode size and low address bits into lane controls and aligned load data.
  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    byte_en    = 4'b1111;
    wdata      = store_data;
    load_data  = shifted;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = signed_load ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'd0, shifted[7:0]};
      end
      SIZE_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = signed_load ? {{16{shifted[15]}}, shifted[15:0]}
                                 : {16'd0, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        // Word, and the reserved encoding which behaves as a word.
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Lapido MEM stage: converts EX/MEM load/store controls into a req/ack
// data-memory transaction, stalls upstream while it is outstanding and
// presents results to mem_wb.
module mem_access_stage
  import lapido_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        memToReg_in,
  input  logic [1:0]  accessSize_in,
  input  logic        signedLoad_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] storeData_in,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busByteEn,
  output logic [31:0] busWData,
  input  logic [31:0] busRData,
  input  logic        busAck,
  output logic        stall,
  output logic        misaligned,
  output logic        busError,
  output logic [31:0] DataOutDataMemory,
  output logic        memToReg,
  output logic [31:0] ALUResult
);

  // Counter runs from 0; the access aborts on the cycle it reads LAST_CNT.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] sdata_q, sdata_d;
  logic        we_q, we_d;
  logic        mtr_q, mtr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        in_idle, in_access, in_done;
  logic        mem_op;
  logic        stall_c, mis_c;

  logic [1:0]  al_addr_lo;
  logic [1:0]  al_size;
  logic [3:0]  al_byte_en;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_mis;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);
  assign mem_op    = memRead_in | memWrite_in;

  // In IDLE the aligner checks the incoming op; afterwards it works from
  // the latched transaction so the bus stays stable until ack.
  assign al_addr_lo = in_idle ? ALUResult_in[1:0] : addr_q[1:0];
  assign al_size    = in_idle ? accessSize_in     : size_q;

  mem_lane_align u_align (
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .signed_load (signed_q),
    .store_data  (sdata_q),
    .rdata       (busRData),
    .byte_en     (al_byte_en),
    .wdata       (al_wdata),
    .load_data   (al_load),
    .misaligned  (al_mis)
  );

  // Next-state, transaction latching, timeout counting and data capture.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    sdata_d  = sdata_q;
    we_d     = we_q;
    mtr_d    = mtr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    stall_c  = 1'b0;
    mis_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (mem_op) begin
          if (al_mis) begin
            mis_c = 1'b1;
          end else begin
            addr_d   = ALUResult_in;
            size_d   = accessSize_in;
            signed_d = signedLoad_in;
            sdata_d  = storeData_in;
            we_d     = memWrite_in;
            mtr_d    = memToReg_in;
            rdata_d  = 32'd0;
            err_d    = 1'b0;
            stall_c  = 1'b1;
            state_d  = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (busAck) begin
          rdata_d = we_q ? 32'd0 : al_load;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_CNT) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-transaction registers; reset abandons any access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      size_q   <= SIZE_WORD;
      signed_q <= 1'b0;
      sdata_q  <= 32'd0;
      we_q     <= 1'b0;
      mtr_q    <= 1'b0;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      sdata_q  <= sdata_d;
      we_q     <= we_d;
      mtr_q    <= mtr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus side is a pure decode of registered state: no path from busAck.
  assign busReq    = in_access;
  assign busWe     = in_access & we_q;
  assign busAddr   = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign busByteEn = in_access ? al_byte_en : 4'd0;
  assign busWData  = in_access ? al_wdata : 32'd0;

  // Pipeline-facing outputs; stall and misaligned are forced low in reset.
  assign stall             = reset_n & stall_c;
  assign misaligned        = reset_n & mis_c;
  assign busError          = in_done & err_q;
  assign DataOutDataMemory = in_done ? rdata_q : 32'd0;
  assign ALUResult         = in_idle ? ALUResult_in : addr_q;
  assign memToReg          = in_idle ? memToReg_in : mtr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (timeout set to 4).
module tb_mem_access_stage;
  import lapido_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        memRead_in, memWrite_in, memToReg_in, signedLoad_in;
  logic [1:0]  accessSize_in;
  logic [31:0] ALUResult_in, storeData_in;
  logic        busReq, busWe;
  logic [31:0] busAddr, busWData, busRData;
  logic [3:0]  busByteEn;
  logic        busAck, stall, misaligned, busError, memToReg;
  logic [31:0] DataOutDataMemory, ALUResult;

  int total = 0;
  int bad   = 0;
  int stall_cnt;
  int req_cnt;

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .memRead_in        (memRead_in),
    .memWrite_in       (memWrite_in),
    .memToReg_in       (memToReg_in),
    .accessSize_in     (accessSize_in),
    .signedLoad_in     (signedLoad_in),
    .ALUResult_in      (ALUResult_in),
    .storeData_in      (storeData_in),
    .busReq            (busReq),
    .busWe             (busWe),
    .busAddr           (busAddr),
    .busByteEn         (busByteEn),
    .busWData          (busWData),
    .busRData          (busRData),
    .busAck            (busAck),
    .stall             (stall),
    .misaligned        (misaligned),
    .busError          (busError),
    .DataOutDataMemory (DataOutDataMemory),
    .memToReg          (memToReg),
    .ALUResult         (ALUResult)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Move to the falling edge and tally stall/busReq for this cycle.
  task automatic sample();
    @(negedge clock);
    stall_cnt += int'(stall);
    req_cnt   += int'(busReq);
  endtask

  task automatic idle_inputs();
    memRead_in    = 1'b0;
    memWrite_in   = 1'b0;
    memToReg_in   = 1'b0;
    signedLoad_in = 1'b0;
    accessSize_in = SIZE_WORD;
    ALUResult_in  = 32'h0000_0055;
    storeData_in  = 32'd0;
    busRData      = 32'd0;
    busAck        = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    stall_cnt = 0;
    req_cnt   = 0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk1("rst_busreq", busReq, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk("rst_data", DataOutDataMemory, 32'd0);
    chk("rst_byteen", {28'd0, busByteEn}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Word load at 0x100, ack in first ACCESS cycle
    stall_cnt = 0; req_cnt = 0;
    memRead_in = 1'b1; memToReg_in = 1'b1; accessSize_in = SIZE_WORD;
    ALUResult_in = 32'h0000_0100; busRData = 32'hDEAD_BEEF; busAck = 1'b1;
    sample();
    chk1("wl_idle_stall", stall, 1'b1);
    chk1("wl_idle_req", busReq, 1'b0);
    next_cycle();
    sample();
    chk("wl_addr", busAddr, 32'h0000_0100);
    chk("wl_be", {28'd0, busByteEn}, 32'h0000_000F);
    chk1("wl_we", busWe, 1'b0);
    next_cycle();
    sample();
    chk("wl_data", DataOutDataMemory, 32'hDEAD_BEEF);
    chk("wl_alu", ALUResult, 32'h0000_0100);
    chk1("wl_mtr", memToReg, 1'b1);
    chk("wl_stalls", 32'(stall_cnt), 32'd2);
    chk("wl_reqs", 32'(req_cnt), 32'd1);
    idle_inputs();
    next_cycle();
    sample();
    chk("pass_alu", ALUResult, 32'h0000_0055);
    chk("pass_data", DataOutDataMemory, 32'd0);
    chk1("pass_stall", stall, 1'b0);

    // Byte load at 0x103, signed then unsigned
    for (int s = 1; s >= 0; s--) begin
      memRead_in = 1'b1; accessSize_in = SIZE_BYTE; signedLoad_in = (s == 1);
      ALUResult_in = 32'h0000_0103; busRData = 32'h80FF_1234; busAck = 1'b1;
      next_cycle();
      sample();
      chk("bl_be", {28'd0, busByteEn}, 32'h0000_0008);
      chk("bl_addr", busAddr, 32'h0000_0100);
      next_cycle();
      sample();
      chk("bl_data", DataOutDataMemory, (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080);
      idle_inputs();
      next_cycle();
    end

    // Half store at 0x202, ack after 3 wait cycles
    stall_cnt = 0; req_cnt = 0;
    memWrite_in = 1'b1; accessSize_in = SIZE_HALF;
    ALUResult_in = 32'h0000_0202; storeData_in = 32'h0000_ABCD; busAck = 1'b0;
    busRData = 32'h1111_2222;
    sample();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      ALUResult_in = 32'h0000_0999;
      storeData_in = 32'h5555_5555;
      sample();
      chk("hs_addr", busAddr, 32'h0000_0200);
      chk("hs_be", {28'd0, busByteEn}, 32'h0000_000C);
      chk("hs_wdata", busWData, 32'hABCD_ABCD);
      chk1("hs_we", busWe, 1'b1);
    end
    next_cycle();
    busAck = 1'b1;
    sample();
    chk1("hs_req_last", busReq, 1'b1);
    next_cycle();
    sample();
    chk("hs_data", DataOutDataMemory, 32'd0);
    chk("hs_alu", ALUResult, 32'h0000_0202);
    chk("hs_stalls", 32'(stall_cnt), 32'd5);
    chk("hs_reqs", 32'(req_cnt), 32'd4);
    idle_inputs();
    next_cycle();

    // Misaligned word load at 0x101, then misaligned half at 0x203
    stall_cnt = 0; req_cnt = 0;
    memRead_in = 1'b1; accessSize_in = SIZE_WORD; ALUResult_in = 32'h0000_0101;
    sample();
    chk1("mis_flag", misaligned, 1'b1);
    chk1("mis_stall", stall, 1'b0);
    chk("mis_data", DataOutDataMemory, 32'd0);
    accessSize_in = SIZE_HALF; ALUResult_in = 32'h0000_0203;
    #1;
    chk1("mis_half_flag", misaligned, 1'b1);
    idle_inputs();
    next_cycle();
    sample();
    chk1("mis_clear", misaligned, 1'b0);
    chk("mis_reqs", 32'(req_cnt), 32'd0);
    next_cycle();

    // Timeout: no ack, TIMEOUT_CYCLES = 4
    stall_cnt = 0; req_cnt = 0;
    memRead_in = 1'b1; accessSize_in = SIZE_WORD; ALUResult_in = 32'h0000_0300;
    busRData = 32'hCAFE_F00D;
    sample();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      sample();
      if (!busReq) break;
    end
    chk("to_reqs", 32'(req_cnt), 32'd4);
    chk1("to_err", busError, 1'b1);
    chk("to_data", DataOutDataMemory, 32'd0);
    chk1("to_stall", stall, 1'b0);
    idle_inputs();
    next_cycle();
    sample();
    chk1("to_err_clear", busError, 1'b0);
    chk1("to_idle_req", busReq, 1'b0);
    next_cycle();

    // Reset asserted mid-ACCESS, then a normal load
    memRead_in = 1'b1; accessSize_in = SIZE_WORD; ALUResult_in = 32'h0000_0400;
    storeData_in = 32'h7777_7777;
    sample();
    next_cycle();
    sample();
    chk1("ra_req_before", busReq, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk1("ra_req", busReq, 1'b0);
    chk1("ra_stall", stall, 1'b0);
    chk("ra_addr", busAddr, 32'd0);
    chk("ra_be", {28'd0, busByteEn}, 32'd0);
    chk("ra_wdata", busWData, 32'd0);
    chk("ra_data", DataOutDataMemory, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    stall_cnt = 0; req_cnt = 0;
    ALUResult_in = 32'h0000_0404; busRData = 32'h1234_5678; busAck = 1'b1;
    sample();
    chk1("ra_new_stall", stall, 1'b1);
    next_cycle();
    sample();
    next_cycle();
    sample();
    chk("ra_new_data", DataOutDataMemory, 32'h1234_5678);
    chk("ra_new_alu", ALUResult, 32'h0000_0404);
    chk("ra_new_stalls", 32'(stall_cnt), 32'd2);
    idle_inputs();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
